fifo_addr_ctrl: RTL and testbench

//  FIFO-mode address controller for one RAM half (x0 or x1) of dpsram_block_4x512x20.

---
 rtl/fifo_addr_ctrl.sv | 104 ++++++++++
 tb/tb_fifo_addr_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_addr_ctrl.sv
// FIFO-mode address controller for one RAM half: write/read pointers, port-2 addresses,
// strobes and level/status flags.
module fifo_addr_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int PTR_W    = 9,
    parameter int ADDR_LSB = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cfg_fifo_en_i,
    input  logic [PTR_W:0]    cfg_almost_full_i,
    input  logic [PTR_W:0]    cfg_almost_empty_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              wr_en_o,
    output logic              rd_en_o,
    output logic [PTR_W:0]    level_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [PTR_W:0] CAPACITY = {1'b1, {PTR_W{1'b0}}};

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;
    logic [PTR_W:0] level;
    logic           full;
    logic           empty;
    logic           en;
    logic           acc_push;
    logic           acc_pop;

    // Handshake: push_i/pop_i are requests; wr_en_o/rd_en_o are the same-cycle grants.
    // A request is consumed only on an edge where its grant is high; a refused request
    // is not queued, and when made against a full/empty FIFO it raises the sticky error.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == CAPACITY);
    assign empty = (level == '0);

    // Gating with rst_n_i keeps the strobes low while the reset is asserted.
    assign en       = cfg_fifo_en_i & ~flush_i & rst_n_i;
    assign acc_push = en & push_i & ~full;
    assign acc_pop  = en & pop_i & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (!cfg_fifo_en_i || flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            wr_ptr_d    = wr_ptr_q + {{PTR_W{1'b0}}, acc_push};
            rd_ptr_d    = rd_ptr_q + {{PTR_W{1'b0}}, acc_pop};
            overflow_d  = overflow_q | (push_i & full);
            underflow_d = underflow_q | (pop_i & empty);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // The wrap bit never reaches the address; bits outside the pointer field stay 0.
    always_comb begin
        wr_addr_o = '0;
        rd_addr_o = '0;
        wr_addr_o[ADDR_LSB +: PTR_W] = wr_ptr_q[PTR_W-1:0];
        rd_addr_o[ADDR_LSB +: PTR_W] = rd_ptr_q[PTR_W-1:0];
    end

    assign wr_en_o        = acc_push;
    assign rd_en_o        = acc_pop;
    assign level_o        = level;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (level >= cfg_almost_full_i);
    assign almost_empty_o = (level <= cfg_almost_empty_i);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_addr_ctrl.sv
// Directed bench for fifo_addr_ctrl: fill/drain, steady push+pop with wrap, simultaneous
// requests at the limits, flush, disable and asynchronous reset.
module tb_fifo_addr_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cfg_fifo_en_i;
  logic [9:0]  cfg_almost_full_i;
  logic [9:0]  cfg_almost_empty_i;
  logic        flush_i;
  logic        push_i;
  logic        pop_i;
  logic [15:0] wr_addr_o;
  logic [15:0] rd_addr_o;
  logic        wr_en_o;
  logic        rd_en_o;
  logic [9:0]  level_o;
  logic        full_o;
  logic        empty_o;
  logic        almost_full_o;
  logic        almost_empty_o;
  logic        overflow_o;
  logic        underflow_o;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  fifo_addr_ctrl #(.ADDR_W(16), .PTR_W(9), .ADDR_LSB(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cfg_fifo_en_i(cfg_fifo_en_i),
    .cfg_almost_full_i(cfg_almost_full_i), .cfg_almost_empty_i(cfg_almost_empty_i),
    .flush_i(flush_i), .push_i(push_i), .pop_i(pop_i),
    .wr_addr_o(wr_addr_o), .rd_addr_o(rd_addr_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .level_o(level_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // driver tasks: inputs change on the falling edge, strobes are sampled 1 ns later
  task automatic drive(input logic p, input logic q, input logic f);
    @(negedge clk_i);
    push_i  = p;
    pop_i   = q;
    flush_i = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    idle();
  endtask

  task automatic do_push(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
  endtask

  task automatic do_pop(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    rst_n_i            = 1'b0;
    cfg_fifo_en_i      = 1'b1;
    cfg_almost_full_i  = 10'd500;
    cfg_almost_empty_i = 10'd4;
    flush_i            = 1'b0;
    push_i             = 1'b1;
    pop_i              = 1'b1;
    #2;
    checks++;
    if (level_o !== 10'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level_o); end
    checks++;
    if ({empty_o, almost_empty_o, full_o, almost_full_o} !== 4'b1100) begin
      errors++; $display("FAIL rst_flags got=%b exp=1100", {empty_o, almost_empty_o, full_o, almost_full_o});
    end
    checks++;
    if ({overflow_o, underflow_o, wr_en_o, rd_en_o} !== 4'b0000) begin
      errors++; $display("FAIL rst_err_en got=%b exp=0000", {overflow_o, underflow_o, wr_en_o, rd_en_o});
    end
    checks++;
    if (wr_addr_o !== 16'h0 || rd_addr_o !== 16'h0) begin
      errors++; $display("FAIL rst_addr got=%h/%h exp=0000/0000", wr_addr_o, rd_addr_o);
    end
    cfg_almost_full_i = 10'd0;
    #1;
    checks++;
    if (almost_full_o !== 1'b1) begin errors++; $display("FAIL rst_af_zero got=%b exp=1", almost_full_o); end
    cfg_almost_full_i = 10'd500;
    @(negedge clk_i);
    push_i  = 1'b0;
    pop_i   = 1'b0;
    rst_n_i = 1'b1;
  endtask

  task automatic test_fill();
    logic [15:0] exp_a;
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      exp_a = 16'(i * 32);
      checks++;
      if (wr_en_o !== 1'b1 || wr_addr_o !== exp_a) begin
        errors++; $display("FAIL fill_wr i=%0d en=%b addr=%h exp_en=1 exp_addr=%h", i, wr_en_o, wr_addr_o, exp_a);
      end
      exp_q.push_back(exp_a);
      tick();
      checks++;
      if (level_o !== 10'(i + 1) || almost_full_o !== (i + 1 >= 500) || full_o !== (i + 1 == 512)) begin
        errors++; $display("FAIL fill_lvl i=%0d level=%0d af=%b full=%b exp_level=%0d", i, level_o, almost_full_o, full_o, i + 1);
      end
    end
    drive(1'b1, 1'b0, 1'b0);
    checks++;
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL fill_513_en got=%b exp=0", wr_en_o); end
    tick();
    checks++;
    if (overflow_o !== 1'b1 || level_o !== 10'd512) begin
      errors++; $display("FAIL fill_513_ovf ovf=%b level=%0d exp=1/512", overflow_o, level_o);
    end
    idle();
  endtask

  task automatic test_drain();
    logic [15:0] exp_a;
    int lvl;
    for (int i = 0; i < 512; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      exp_a = exp_q.pop_front();
      checks++;
      if (rd_en_o !== 1'b1 || rd_addr_o !== exp_a) begin
        errors++; $display("FAIL drain_rd i=%0d en=%b addr=%h exp_en=1 exp_addr=%h", i, rd_en_o, rd_addr_o, exp_a);
      end
      tick();
      lvl = 511 - i;
      checks++;
      if (level_o !== 10'(lvl) || almost_empty_o !== (lvl <= 4) || empty_o !== (lvl == 0)) begin
        errors++; $display("FAIL drain_lvl i=%0d level=%0d ae=%b empty=%b exp_level=%0d", i, level_o, almost_empty_o, empty_o, lvl);
      end
    end
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL drain_ovf_sticky got=%b exp=1", overflow_o); end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (rd_en_o !== 1'b0) begin errors++; $display("FAIL drain_extra_en got=%b exp=0", rd_en_o); end
    tick();
    checks++;
    if (underflow_o !== 1'b1 || level_o !== 10'd0) begin
      errors++; $display("FAIL drain_extra_unf unf=%b level=%0d exp=1/0", underflow_o, level_o);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int wi;
    int ri;
    int wraps;
    do_flush();
    do_push(5);
    wi = 5;
    ri = 0;
    wraps = 0;
    for (int c = 0; c < 1000; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (wr_en_o !== 1'b1 || rd_en_o !== 1'b1 || wr_addr_o !== 16'((wi % 512) * 32) || rd_addr_o !== 16'((ri % 512) * 32)) begin
        errors++; $display("FAIL b2b_strobe c=%0d en=%b%b wa=%h ra=%h exp_wa=%h exp_ra=%h", c, wr_en_o, rd_en_o,
                           wr_addr_o, rd_addr_o, 16'((wi % 512) * 32), 16'((ri % 512) * 32));
      end
      if (wr_addr_o == 16'h3FE0) wraps++;
      wi++;
      ri++;
      tick();
      checks++;
      if (level_o !== 10'd5 || {full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o} !== 6'b0) begin
        errors++; $display("FAIL b2b_level c=%0d level=%0d flags=%b exp=5/000000", c, level_o,
                           {full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o});
      end
    end
    checks++;
    if (wraps < 1) begin errors++; $display("FAIL b2b_wrap got=%0d exp>=1", wraps); end
    idle();
  endtask

  task automatic test_simul_full();
    do_flush();
    do_push(512);
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (rd_en_o !== 1'b1 || wr_en_o !== 1'b0) begin
      errors++; $display("FAIL full_pp_en rd=%b wr=%b exp=1/0", rd_en_o, wr_en_o);
    end
    tick();
    checks++;
    if (level_o !== 10'd511 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL full_pp_state level=%0d ovf=%b exp=511/1", level_o, overflow_o);
    end
    idle();
  endtask

  task automatic test_simul_empty();
    do_flush();
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (wr_en_o !== 1'b1 || rd_en_o !== 1'b0) begin
      errors++; $display("FAIL empty_pp_en wr=%b rd=%b exp=1/0", wr_en_o, rd_en_o);
    end
    tick();
    checks++;
    if (level_o !== 10'd1 || underflow_o !== 1'b1) begin
      errors++; $display("FAIL empty_pp_state level=%0d unf=%b exp=1/1", level_o, underflow_o);
    end
    idle();
  endtask

  task automatic test_flush();
    do_flush();
    do_push(513);
    do_pop(412);
    checks++;
    if (level_o !== 10'd100 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL flush_setup level=%0d ovf=%b exp=100/1", level_o, overflow_o);
    end
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (wr_en_o !== 1'b0 || rd_en_o !== 1'b0) begin
      errors++; $display("FAIL flush_en wr=%b rd=%b exp=0/0", wr_en_o, rd_en_o);
    end
    tick();
    checks++;
    if (level_o !== 10'd0 || empty_o !== 1'b1 || overflow_o !== 1'b0 || wr_addr_o !== 16'h0 || rd_addr_o !== 16'h0) begin
      errors++; $display("FAIL flush_state level=%0d empty=%b ovf=%b wa=%h ra=%h exp=0/1/0/0000/0000",
                         level_o, empty_o, overflow_o, wr_addr_o, rd_addr_o);
    end
    idle();
  endtask

  task automatic test_disable();
    do_push(3);
    @(negedge clk_i);
    cfg_fifo_en_i = 1'b0;
    push_i = 1'b1;
    pop_i  = 1'b1;
    #1;
    checks++;
    if (wr_en_o !== 1'b0 || rd_en_o !== 1'b0) begin
      errors++; $display("FAIL dis_en wr=%b rd=%b exp=0/0", wr_en_o, rd_en_o);
    end
    tick();
    checks++;
    if (level_o !== 10'd0 || wr_addr_o !== 16'h0 || empty_o !== 1'b1) begin
      errors++; $display("FAIL dis_state level=%0d wa=%h empty=%b exp=0/0000/1", level_o, wr_addr_o, empty_o);
    end
    @(negedge clk_i);
    cfg_fifo_en_i = 1'b1;
    idle();
  endtask

  task automatic test_async_reset();
    do_flush();
    do_push(37);
    @(negedge clk_i);
    push_i = 1'b1;
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (level_o !== 10'd0 || empty_o !== 1'b1 || wr_addr_o !== 16'h0 || wr_en_o !== 1'b0) begin
      errors++; $display("FAIL areset level=%0d empty=%b wa=%h wr_en=%b exp=0/1/0000/0", level_o, empty_o, wr_addr_o, wr_en_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    checks++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 16'h0) begin
      errors++; $display("FAIL areset_first_push en=%b wa=%h exp=1/0000", wr_en_o, wr_addr_o);
    end
    tick();
    checks++;
    if (level_o !== 10'd1 || wr_addr_o !== 16'h0020) begin
      errors++; $display("FAIL areset_after level=%0d wa=%h exp=1/0020", level_o, wr_addr_o);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_simul_full();
    test_simul_empty();
    test_flush();
    test_disable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
